// File: rtl/sha_block_sequencer.sv
// SHA-256 single-block sequencer for a fixed 32-byte message.
// Builds the padded 512-bit block and streams it as 16 words to the
// compression core. It then waits for the core, with a watchdog, and holds
// the digest on a valid/ready output.
module sha_block_sequencer #(
  parameter int MSG_LEN_BITS   = 256,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [255:0] msg_block,
  output logic         core_start,
  output logic         core_word_valid,
  input  logic         core_word_ready,
  output logic [31:0]  core_word,
  input  logic         core_done,
  input  logic [255:0] core_digest,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] dig_data,
  output logic         busy,
  output logic         err_timeout
);

  typedef enum logic [2:0] {IDLE, START, SEND, WAIT_CORE, OUTPUT} state_t;

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      LEN_WORD  = 32'(MSG_LEN_BITS);

  state_t         state, state_n;
  logic [3:0]     word_idx, word_idx_n;
  logic [CNT_W-1:0] wdog, wdog_n;
  logic [255:0]   blk, blk_n;
  logic [255:0]   dig_n;
  logic [31:0]    word_n;
  logic           err_n;

  // Padded-block word i: message words first (W0 at the top of the block),
  // then the 0x80 pad byte, zero fill, and the bit length in W15.
  function automatic logic [31:0] w_sel(input logic [255:0] b, input logic [3:0] i);
    logic [31:0] w;
    if (!i[3])          w = b[{~i[2:0], 5'd0} +: 32];
    else if (i == 4'd8) w = 32'h8000_0000;
    else if (i == 4'd15) w = LEN_WORD;
    else                w = 32'h0;
    return w;
  endfunction

  // Next-state, word index, watchdog and capture logic.
  always_comb begin
    state_n    = state;
    word_idx_n = word_idx;
    wdog_n     = wdog;
    blk_n      = blk;
    dig_n      = dig_data;
    err_n      = err_timeout;
    case (state)
      IDLE: begin
        if (msg_valid && msg_ready) begin
          blk_n   = msg_block;
          state_n = START;
        end
      end
      START: begin
        word_idx_n = 4'd0;
        state_n    = SEND;
      end
      SEND: begin
        if (core_word_valid && core_word_ready) begin
          word_idx_n = word_idx + 4'd1;
          if (word_idx == 4'd15) state_n = WAIT_CORE;
        end
      end
      WAIT_CORE: begin
        // done takes priority over a watchdog expiry in the same cycle
        if (core_done) begin
          dig_n   = core_digest;
          wdog_n  = '0;
          state_n = OUTPUT;
        end else if (wdog == WDOG_LAST) begin
          err_n   = 1'b1;
          wdog_n  = '0;
          state_n = IDLE;
        end else begin
          wdog_n  = wdog + 1'b1;
        end
      end
      OUTPUT: begin
        if (dig_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // word is registered from the next index so it holds steady under stall
    word_n = (state_n == SEND) ? w_sel(blk_n, word_idx_n) : 32'h0;
  end

  // State and registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      word_idx        <= '0;
      wdog            <= '0;
      blk             <= '0;
      msg_ready       <= 1'b0;
      core_start      <= 1'b0;
      core_word_valid <= 1'b0;
      core_word       <= '0;
      dig_valid       <= 1'b0;
      dig_data        <= '0;
      busy            <= 1'b0;
      err_timeout     <= 1'b0;
    end else begin
      state           <= state_n;
      word_idx        <= word_idx_n;
      wdog            <= wdog_n;
      blk             <= blk_n;
      msg_ready       <= (state_n == IDLE);
      core_start      <= (state_n == START);
      core_word_valid <= (state_n == SEND);
      core_word       <= word_n;
      dig_valid       <= (state_n == OUTPUT);
      dig_data        <= dig_n;
      busy            <= (state_n != IDLE);
      err_timeout     <= err_n;
    end
  end

endmodule

// File: tb/tb_sha_block_sequencer.sv
// Directed bench for sha_block_sequencer: word stream scoreboard,
// backpressure, digest hold, watchdog and reset behaviour.
module tb_sha_block_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         msg_valid, msg_ready;
  logic [255:0] msg_block;
  logic         core_start, core_word_valid, core_word_ready;
  logic [31:0]  core_word;
  logic         core_done;
  logic [255:0] core_digest;
  logic         dig_valid, dig_ready;
  logic [255:0] dig_data;
  logic         busy, err_timeout;

  logic ready_fixed = 1'b1;
  logic rnd_mode    = 1'b0;
  logic rnd_bit     = 1'b1;

  int total = 0;
  int bad   = 0;
  int words_seen = 0;
  logic [31:0]  wq[$];
  logic [255:0] dq[$];
  logic         stall_prev = 1'b0;
  logic [31:0]  prev_word  = '0;

  localparam logic [255:0] INC_MSG =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] ZERO_DIG =
    256'h66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925;

  always #5 clk = ~clk;

  assign core_word_ready = rnd_mode ? rnd_bit : ready_fixed;

  // ~30% ready duty while in random mode
  always @(posedge clk) rnd_bit <= ($urandom_range(0, 99) < 30);

  sha_block_sequencer #(.MSG_LEN_BITS(256), .TIMEOUT_CYCLES(8), .CNT_W(11)) dut (
    .clk(clk), .rst(rst),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_block(msg_block),
    .core_start(core_start), .core_word_valid(core_word_valid),
    .core_word_ready(core_word_ready), .core_word(core_word),
    .core_done(core_done), .core_digest(core_digest),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
    .busy(busy), .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word monitor: pops expected words on each handshake, checks stall stability
  always @(negedge clk) begin
    if (stall_prev && core_word_valid) chk("word_stable", core_word, prev_word);
    if (core_word_valid && core_word_ready) begin
      if (wq.size() == 0) chk("extra_word", 1'b1, 1'b0 ^ core_word_valid ^ 1'b1);
      else chk("word", core_word, wq.pop_front());
      words_seen++;
    end
    stall_prev = core_word_valid && !core_word_ready && !rst;
    prev_word  = core_word;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_msg(input logic [255:0] b);
    logic [255:0] t;
    for (int i = 0; i < 50 && !msg_ready; i++) tick();
    chk("msg_ready_wait", msg_ready, 1'b1);
    t = b;
    for (int i = 0; i < 8; i++) begin
      wq.push_back(t[255:224]);
      t = t << 32;
    end
    wq.push_back(32'h8000_0000);
    for (int i = 0; i < 6; i++) wq.push_back(32'h0);
    wq.push_back(32'h0000_0100);
    words_seen = 0;
    msg_valid = 1'b1;
    msg_block = b;
    tick();
    msg_valid = 1'b0;
    chk("start_pulse", core_start, 1'b1);
    chk("start_no_word", core_word_valid, 1'b0);
    chk("start_no_ready", msg_ready, 1'b0);
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 2000 && words_seen < n; i++) tick();
    chk("words_wait", words_seen, n);
  endtask

  task automatic finish_digest(input logic [255:0] d);
    core_done   = 1'b1;
    core_digest = d;
    dq.push_back(d);
    tick();
    core_done   = 1'b0;
    core_digest = '0;
    chk("dig_valid", dig_valid, 1'b1);
    if (dq.size() != 0) chk("dig_data", dig_data, dq.pop_front());
    dig_ready = 1'b1;
    tick();
    dig_ready = 1'b0;
    chk("dig_drop", dig_valid, 1'b0);
    chk("dig_retain", dig_data, d);
    chk("idle_ready", msg_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [255:0] rnd_msg;
    msg_valid = 1'b0; msg_block = '0; core_done = 1'b0;
    core_digest = '0; dig_ready = 1'b0;

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_msg_ready", msg_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dig_data", dig_data, '0);
    rst = 1'b0;
    tick();
    chk("post_rst_msg_ready", msg_ready, 1'b1);
    chk("post_rst_start", core_start, 1'b0);
    chk("post_rst_wvalid", core_word_valid, 1'b0);
    chk("post_rst_word", core_word, '0);
    chk("post_rst_dvalid", dig_valid, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_err", err_timeout, 1'b0);

    // Word order, core always ready; first word one cycle after start
    send_msg(INC_MSG);
    tick();
    chk("w0_after_start", core_word_valid, 1'b1);
    chk("start_one_cycle", core_start, 1'b0);
    chk("w0_value", core_word, 32'h0001_0203);
    chk("busy_send", busy, 1'b1);
    wait_words(16);
    chk("wait_no_valid", core_word_valid, 1'b0);
    chk("wq_empty", wq.size(), 0);
    finish_digest(256'hdead_beef_0000_0001);

    // Backpressure with random ready
    rnd_msg = {$urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom};
    rnd_mode = 1'b1;
    send_msg(rnd_msg);
    wait_words(16);
    rnd_mode = 1'b0;
    chk("bp_wq_empty", wq.size(), 0);
    finish_digest({rnd_msg[127:0], rnd_msg[255:128]});

    // Digest path: zero message, done five cycles after W15, held 10 cycles
    send_msg('0);
    wait_words(16);
    repeat (4) tick();
    core_done = 1'b1;
    core_digest = ZERO_DIG;
    tick();
    core_done = 1'b0;
    core_digest = '0;
    chk("zd_valid", dig_valid, 1'b1);
    chk("zd_data", dig_data, ZERO_DIG);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("zd_hold_valid", dig_valid, 1'b1);
      chk("zd_hold_data", dig_data, ZERO_DIG);
    end
    dig_ready = 1'b1;
    tick();
    dig_ready = 1'b0;
    chk("zd_drop", dig_valid, 1'b0);
    chk("zd_ready", msg_ready, 1'b1);
    chk("zd_retain", dig_data, ZERO_DIG);

    // Spurious done in IDLE and SEND; done in the watchdog expiry cycle wins
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("sp_idle_ready", msg_ready, 1'b1);
    chk("sp_idle_busy", busy, 1'b0);
    chk("sp_idle_dvalid", dig_valid, 1'b0);
    send_msg(INC_MSG);
    repeat (4) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("sp_send_busy", busy, 1'b1);
    chk("sp_send_dvalid", dig_valid, 1'b0);
    wait_words(16);
    chk("sp_wq_empty", wq.size(), 0);
    repeat (7) tick();
    chk("exp_still_wait", busy, 1'b1);
    finish_digest(ZERO_DIG ^ INC_MSG);
    chk("exp_no_err", err_timeout, 1'b0);

    // Watchdog: no done for 8 WAIT_CORE cycles
    send_msg(INC_MSG);
    wait_words(16);
    repeat (7) tick();
    chk("to_pre_err", err_timeout, 1'b0);
    chk("to_pre_busy", busy, 1'b1);
    tick();
    chk("to_err", err_timeout, 1'b1);
    chk("to_idle_busy", busy, 1'b0);
    chk("to_idle_ready", msg_ready, 1'b1);
    chk("to_dvalid", dig_valid, 1'b0);
    send_msg('0);
    wait_words(16);
    repeat (2) tick();
    finish_digest(ZERO_DIG);
    chk("to_err_sticky", err_timeout, 1'b1);

    // Reset asserted mid-SEND at word 5
    send_msg(INC_MSG);
    wait_words(5);
    chk("mid_w5", core_word, 32'h1415_1617);
    rst = 1'b1;
    #1;
    wq.delete();
    chk("mrst_msg_ready", msg_ready, 1'b0);
    chk("mrst_start", core_start, 1'b0);
    chk("mrst_wvalid", core_word_valid, 1'b0);
    chk("mrst_word", core_word, '0);
    chk("mrst_dvalid", dig_valid, 1'b0);
    chk("mrst_dig", dig_data, '0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_err", err_timeout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mrst_no_start", core_start, 1'b0);
      chk("mrst_no_word", core_word_valid, 1'b0);
    end
    chk("mrst_idle_ready", msg_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha_block_sequencer.md
Name: sha_block_sequencer

Overview:
Sequences one SHA-256 hash of a fixed 32-byte message. It accepts the 256-bit big-endian block from the message buffer and forms the single padded 512-bit SHA-256 block. It streams that block as 16 32-bit words to the compression core, waits for the core to finish, and holds the 256-bit digest on a valid/ready output. A watchdog flags a core that never completes.

Parameters:
MSG_LEN_BITS, 256, message length in bits written into W15; fixed 256 for this build, must be < 2^32.
TIMEOUT_CYCLES, 1024, max cycles in WAIT_CORE before error; must be >= 2.
CNT_W, 11, watchdog counter width; 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
msg_valid  in  1  message block available
msg_ready  out  1  sequencer accepts block
msg_block  in  256  message, first byte at [255:248]
core_start  out  1  one-cycle pulse: core initialises state to SHA-256 IV
core_word_valid  out  1  word presented to core
core_word_ready  in  1  core accepts word
core_word  out  32  message schedule word W[i]
core_done  in  1  one-cycle pulse: compression finished
core_digest  in  256  final hash, sampled when core_done=1
dig_valid  out  1  digest held
dig_ready  in  1  downstream accepts digest
dig_data  out  256  digest, H0 at [255:224]
busy  out  1  high in any state except IDLE
err_timeout  out  1  sticky; set on watchdog expiry

Behaviour:
- Reset, asynchronous on rst=1:
  - state=IDLE, word_idx=0, wdog=0, block register=0.
  - Outputs: msg_ready=0, core_start=0, core_word_valid=0, core_word=0, dig_valid=0, dig_data=0, busy=0, err_timeout=0.
  - Reset mid-operation abandons the hash; no pulse is emitted after deassertion.
- msg_ready=1 only in IDLE, registered. A transfer occurs when msg_valid&&msg_ready.
- FSM states: IDLE, START, SEND, WAIT_CORE, OUTPUT.
- IDLE: on transfer, latch msg_block and go to START. msg_ready drops the next cycle.
- START: core_start=1 for exactly one cycle; word_idx=0; go to SEND.
- SEND:
  - core_word_valid=1; core_word=W[word_idx].
  - W[i] for i=0..7 is msg_block[255-32i -: 32].
  - W8=32'h80000000; W9..W14=0; W15=MSG_LEN_BITS (32'h00000100).
  - On core_word_valid&&core_word_ready, word_idx increments. After W15 is accepted, go to WAIT_CORE with core_word_valid=0 the next cycle.
  - core_word and core_word_valid stay stable while ready is low.
  - Back-to-back acceptance gives 16 words in 16 cycles.
- WAIT_CORE: wdog increments each cycle.
  - core_done=1: capture core_digest into dig_data, dig_valid=1, go to OUTPUT, wdog=0.
  - wdog reaches TIMEOUT_CYCLES-1 with no core_done: err_timeout=1, return to IDLE, dig_valid stays 0.
  - core_done in the expiry cycle: done wins, no error.
- OUTPUT: dig_valid held, dig_data stable until dig_ready. On handshake, dig_valid=0 next cycle and return to IDLE. dig_data retains its last value.
- core_done outside WAIT_CORE is ignored, no state change. core_word_ready outside SEND is ignored.
- err_timeout clears only on rst.
- Minimum latency, core ready always and done N cycles after the last word:
  - msg accept → core_start: 1 cycle.
  - First word valid 1 cycle after core_start.
  - dig_valid 1 cycle after core_done.
- busy is registered from state != IDLE.

Test Plan:
1. Reset check: hold rst 3 cycles, release → msg_ready=1, all other outputs 0. Assert rst during SEND at word 5 → every output is at its reset value on the same edge; no core_start after release.
2. Word order: msg_block = 256'h000102...1F, core_word_ready always 1.
   - Words, in order: 00010203, 04050607, ..., 1C1D1E1F, 80000000, 0 ×6, 00000100.
   - core_start precedes W0 by 1 cycle.
3. Backpressure: core_word_ready random 30% duty → same 16 words, none duplicated or dropped; core_word stable while stalled.
4. Digest path: zero message; model core returns 66687aad f862bd77 6c8fc18b 8e9f8e20 08971485 6ee233b3 902a591d 0d5f2925 five cycles after W15.
   - dig_valid next cycle with that value.
   - dig_ready held low 10 cycles keeps value stable.
   - After the handshake, msg_ready=1.
5. Timeout: TIMEOUT_CYCLES=8, core never pulses done → err_timeout=1 after 8 WAIT_CORE cycles, state IDLE, dig_valid=0. A following message still hashes normally with err_timeout still 1.
6. Spurious done: core_done pulsed in IDLE and in SEND → no state change, word stream unaffected.
